// File: rtl/ws2812_pix_if.sv
// Pixel RAM read port between a WS2812 channel and its strip RAM.
// Data returns one cycle after the read enable.
interface ws2812_pix_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] pix_raddr;
   logic              pix_re;
   logic [23:0]       pix_rdata;

   modport master (
      output pix_raddr,
      output pix_re,
      input  pix_rdata
   );

   modport slave (
      input  pix_raddr,
      input  pix_re,
      output pix_rdata
   );
endinterface

// File: rtl/ws2812_channel_tx.sv
// Single-channel WS2812 serializer: RAM pixels to MSB-first NRZ pulses.
// Each frame ends with a latch gap; done marks the final gap cycle.
module ws2812_channel_tx #(
   parameter int NUM_LEDS = 64,
   parameter int ADDR_W   = 8,
   parameter int T_BIT    = 125,
   parameter int T0H      = 40,
   parameter int T1H      = 80,
   parameter int T_RESET  = 30000
) (
   input  logic         sys_clk,
   input  logic         rst_n,
   input  logic         start,
   ws2812_pix_if.master pix,
   output logic         dout,
   output logic         busy,
   output logic         done
);
   localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int PH_W  = $clog2(T_BIT);
   localparam int GAP_W = (T_RESET > 1) ? $clog2(T_RESET) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LEDS - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(T_BIT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(T_RESET - 1);
   localparam logic [PH_W-1:0]  HI0      = PH_W'(T0H);
   localparam logic [PH_W-1:0]  HI1      = PH_W'(T1H);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SEND,
      GAP
   } state_t;

   state_t            state, state_n;
   logic [PH_W-1:0]   phase, phase_n;
   logic [4:0]        bit_cnt, bit_n;
   logic [IDX_W-1:0]  pix_idx, pix_idx_n;
   logic [GAP_W-1:0]  gap_cnt, gap_n;
   logic [23:0]       shift_reg, shift_n;
   logic [23:0]       next_reg, next_n;
   logic [ADDR_W-1:0] raddr_n;
   logic              re_n, dout_n, busy_n, done_n;
   logic [PH_W-1:0]   thr;

   // Next-state, datapath and registered-output values
   always_comb begin
      state_n   = state;
      phase_n   = phase;
      bit_n     = bit_cnt;
      pix_idx_n = pix_idx;
      gap_n     = gap_cnt;
      shift_n   = shift_reg;
      next_n    = next_reg;
      raddr_n   = pix.pix_raddr;
      re_n      = 1'b0;
      thr       = HI0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n   = FETCH;
               pix_idx_n = '0;
            end
         end
         FETCH: state_n = LOAD;
         LOAD: begin
            state_n   = SEND;
            shift_n   = pix.pix_rdata;
            phase_n   = '0;
            bit_n     = 5'd23;
            pix_idx_n = '0;
         end
         SEND: begin
            if (bit_cnt == 5'd23 && phase == PH_W'(2))
               next_n = pix.pix_rdata;
            if (phase == PH_LAST) begin
               phase_n = '0;
               if (bit_cnt != 5'd0) begin
                  shift_n = {shift_reg[22:0], 1'b0};
                  bit_n   = bit_cnt - 5'd1;
               end else if (pix_idx != IDX_LAST) begin
                  shift_n   = next_reg;
                  pix_idx_n = pix_idx + IDX_W'(1);
                  bit_n     = 5'd23;
               end else begin
                  state_n = GAP;
                  gap_n   = '0;
               end
            end else begin
               phase_n = phase + PH_W'(1);
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST)
               state_n = IDLE;
            else
               gap_n = gap_cnt + GAP_W'(1);
         end
         default: state_n = IDLE;
      endcase

      if (state == IDLE && state_n == FETCH) begin
         re_n    = 1'b1;
         raddr_n = '0;
      end else if (state_n == SEND && bit_n == 5'd23 &&
                   phase_n == PH_W'(1) && pix_idx_n != IDX_LAST) begin
         re_n    = 1'b1;
         raddr_n = ADDR_W'(pix_idx_n) + ADDR_W'(1);
      end

      thr    = shift_n[23] ? HI1 : HI0;
      dout_n = (state_n == SEND) && (phase_n < thr);
      busy_n = (state_n != IDLE);
      done_n = (state_n == GAP) && (gap_n == GAP_LAST);
   end

   // State, counters, shift registers and all outputs
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         phase         <= '0;
         bit_cnt       <= '0;
         pix_idx       <= '0;
         gap_cnt       <= '0;
         shift_reg     <= '0;
         next_reg      <= '0;
         pix.pix_raddr <= '0;
         pix.pix_re    <= 1'b0;
         dout          <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state         <= state_n;
         phase         <= phase_n;
         bit_cnt       <= bit_n;
         pix_idx       <= pix_idx_n;
         gap_cnt       <= gap_n;
         shift_reg     <= shift_n;
         next_reg      <= next_n;
         pix.pix_raddr <= raddr_n;
         pix.pix_re    <= re_n;
         dout          <= dout_n;
         busy          <= busy_n;
         done          <= done_n;
      end
   end
endmodule

// File: tb/tb_ws2812_channel_tx.sv
// Scoreboard bench: two channels (2 pixels and 1 pixel per frame).
// Stimulus queues expected reads, bits and done pulses; a monitor checks them.
module tb_ws2812_channel_tx;
   localparam int TB_BIT = 125;
   localparam int TRST   = 3000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   logic dout_a, busy_a, done_a;
   logic dout_b, busy_b, done_b;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   logic [23:0] ram [2][4];
   int          nled [2];

   int exp_re_cyc  [2][$];
   int exp_re_addr [2][$];
   int exp_rise    [2][$];
   int exp_len     [2][$];
   int exp_done    [2][$];

   ws2812_pix_if #(.ADDR_W(8)) pa ();
   ws2812_pix_if #(.ADDR_W(8)) pb ();

   ws2812_channel_tx #(
      .NUM_LEDS(2), .ADDR_W(8), .T_BIT(TB_BIT),
      .T0H(40), .T1H(80), .T_RESET(TRST)
   ) dut_a (
      .sys_clk(clk), .rst_n(rst_n), .start(start_a), .pix(pa),
      .dout(dout_a), .busy(busy_a), .done(done_a)
   );

   ws2812_channel_tx #(
      .NUM_LEDS(1), .ADDR_W(8), .T_BIT(TB_BIT),
      .T0H(40), .T1H(80), .T_RESET(TRST)
   ) dut_b (
      .sys_clk(clk), .rst_n(rst_n), .start(start_b), .pix(pb),
      .dout(dout_b), .busy(busy_b), .done(done_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strip RAMs with one-cycle read latency
   always @(posedge clk) begin
      if (pa.pix_re) pa.pix_rdata <= ram[0][pa.pix_raddr[1:0]];
      if (pb.pix_re) pb.pix_rdata <= ram[1][pb.pix_raddr[1:0]];
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Expected reads, bit pulses and done for a full frame started in cycle s
   task automatic push_frame(input int d, input int s);
      int first;
      logic [23:0] px;
      first = s + 3;
      exp_re_cyc[d].push_back(s + 1);
      exp_re_addr[d].push_back(0);
      for (int p = 0; p < nled[d]; p++) begin
         if (p > 0) begin
            exp_re_cyc[d].push_back(first + (p - 1) * 24 * TB_BIT + 1);
            exp_re_addr[d].push_back(p);
         end
         px = ram[d][p];
         for (int b = 0; b < 24; b++) begin
            exp_rise[d].push_back(first + (p * 24 + b) * TB_BIT);
            exp_len[d].push_back(px[23 - b] ? 80 : 40);
         end
      end
      exp_done[d].push_back(first + nled[d] * 24 * TB_BIT + TRST - 1);
   endtask

   // Monitor: compare every DUT output event against the queues
   logic [1:0] re_s, dout_s, done_s, prev;
   logic [7:0] addr_s [2];
   int         rise_at [2];
   assign re_s   = {pb.pix_re, pa.pix_re};
   assign dout_s = {dout_b, dout_a};
   assign done_s = {done_b, done_a};
   assign addr_s[0] = pa.pix_raddr;
   assign addr_s[1] = pb.pix_raddr;
   initial prev = 2'b00;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (re_s[d]) begin
            if (exp_re_cyc[d].size() == 0) begin
               chk($sformatf("re_extra%0d", d), cyc, -1);
            end else begin
               chk($sformatf("re_cyc%0d", d), cyc, exp_re_cyc[d].pop_front());
               chk($sformatf("re_addr%0d", d), int'(addr_s[d]),
                   exp_re_addr[d].pop_front());
            end
         end
         if (dout_s[d] && !prev[d]) rise_at[d] <= cyc;
         if (!dout_s[d] && prev[d]) begin
            if (exp_rise[d].size() == 0) begin
               chk($sformatf("bit_extra%0d", d), cyc, -1);
            end else begin
               chk($sformatf("bit_rise%0d", d), rise_at[d], exp_rise[d].pop_front());
               chk($sformatf("bit_high%0d", d), cyc - rise_at[d],
                   exp_len[d].pop_front());
            end
         end
         if (done_s[d]) begin
            if (exp_done[d].size() == 0)
               chk($sformatf("done_extra%0d", d), cyc, -1);
            else
               chk($sformatf("done_cyc%0d", d), cyc, exp_done[d].pop_front());
         end
      end
      prev <= dout_s;
   end

   // Channel B: single pixel, alternating bits
   initial begin
      wait_cyc(10);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
   end

   // Channel A: main sequence, reset abort and summary
   initial begin
      ram[0][0] = 24'hFF0000;
      ram[0][1] = 24'h000001;
      ram[0][2] = 24'h0;
      ram[0][3] = 24'h0;
      ram[1][0] = 24'hAAAAAA;
      ram[1][1] = 24'h0;
      ram[1][2] = 24'h0;
      ram[1][3] = 24'h0;
      nled[0] = 2;
      nled[1] = 1;
      push_frame(1, 10);

      wait_cyc(1);
      chk("rst_dout_a", int'(dout_a), 0);
      chk("rst_busy_a", int'(busy_a), 0);
      chk("rst_done_a", int'(done_a), 0);
      chk("rst_re_a", int'(pa.pix_re), 0);
      chk("rst_addr_a", int'(pa.pix_raddr), 0);
      chk("rst_dout_b", int'(dout_b), 0);
      chk("rst_busy_b", int'(busy_b), 0);
      chk("rst_re_b", int'(pb.pix_re), 0);
      wait_cyc(2);
      rst_n = 1'b1;

      push_frame(0, 10);
      wait_cyc(10);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("busy_after_start", int'(busy_a), 1);

      for (int i = 0; i < 3; i++) begin
         wait_cyc(i == 0 ? 2000 : (i == 1 ? 7000 : 9012));
         start_a = 1'b1;
         @(negedge clk);
         start_a = 1'b0;
      end
      chk("busy_after_done", int'(busy_a), 0);

      push_frame(0, 9013);
      wait_cyc(9013);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("busy_restart", int'(busy_a), 1);

      exp_re_cyc[0].push_back(18021);
      exp_re_addr[0].push_back(0);
      exp_re_cyc[0].push_back(18024);
      exp_re_addr[0].push_back(1);
      for (int b = 0; b < 13; b++) begin
         exp_rise[0].push_back(18023 + b * TB_BIT);
         exp_len[0].push_back(b < 8 ? 80 : 40);
      end
      exp_rise[0].push_back(18023 + 13 * TB_BIT);
      exp_len[0].push_back(2);
      wait_cyc(18020);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;

      wait_cyc(19649);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_dout", int'(dout_a), 0);
      chk("abort_busy", int'(busy_a), 0);
      chk("abort_re", int'(pa.pix_re), 0);
      chk("abort_addr", int'(pa.pix_raddr), 0);
      wait_cyc(19652);
      rst_n = 1'b1;
      wait_cyc(19660);
      chk("abort_no_resume", int'(busy_a), 0);

      push_frame(0, 19670);
      wait_cyc(19670);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_cyc(28672);
      chk("busy_last_gap", int'(busy_a), 1);
      @(negedge clk);
      chk("busy_end", int'(busy_a), 0);

      wait_cyc(29000);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("left_re%0d", d), exp_re_cyc[d].size(), 0);
         chk($sformatf("left_bits%0d", d), exp_rise[d].size(), 0);
         chk($sformatf("left_done%0d", d), exp_done[d].size(), 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
